// File: rtl/demux16_deser.sv
// Serial-to-16-bit deserializer: a 4-bit index steers each accepted bit into an assembly register.
// Optional even-parity frame bit and perr output when DEMUX16_DESER_PARITY_EN is defined.
module demux16_deser (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        sync,
  output logic [15:0] D,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DEMUX16_DESER_PARITY_EN
  output logic        perr,
`endif
  output logic [3:0]  sel
);

`ifdef DEMUX16_DESER_PARITY_EN
  localparam int IW = 5;
  localparam logic [IW-1:0] LAST = 5'd16;
`else
  localparam int IW = 4;
  localparam logic [IW-1:0] LAST = 4'd15;
`endif

  logic [IW-1:0] idx_q;
  logic [IW-1:0] eff_idx;
  logic [15:0]   asm_q;
  logic [15:0]   asm_wr;
  logic          word_end;
  logic          accept;

  // sync restarts the frame in the same cycle, so a bit arriving with it lands at position 0
  always_comb begin
    eff_idx   = sync ? '0 : idx_q;
    word_end  = (eff_idx == LAST);
    din_ready = !(word_end && out_valid && !out_ready);
    accept    = din_valid && din_ready;
    asm_wr    = sync ? '0 : asm_q;
`ifdef DEMUX16_DESER_PARITY_EN
    if (!eff_idx[4]) asm_wr[eff_idx[3:0]] = din;
`else
    asm_wr[eff_idx] = din;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      asm_q     <= '0;
      D         <= '0;
      out_valid <= 1'b0;
`ifdef DEMUX16_DESER_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (word_end) begin
          D         <= asm_wr;
          out_valid <= 1'b1;
          idx_q     <= '0;
          asm_q     <= '0;
`ifdef DEMUX16_DESER_PARITY_EN
          perr      <= (^asm_q) ^ din;
`endif
        end else begin
          asm_q <= asm_wr;
          idx_q <= eff_idx + IW'(1);
        end
      end else if (sync) begin
        idx_q <= '0;
        asm_q <= '0;
      end
    end
  end

`ifdef DEMUX16_DESER_PARITY_EN
  // the parity slot is reported as the last data position
  assign sel = idx_q[4] ? 4'd15 : idx_q[3:0];
`else
  assign sel = idx_q;
`endif

endmodule
